// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle RISC-V core: instruction constants,
// fetch fault codes and fetch FSM states.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OP_LW  = 7'b000_0011;
  localparam logic [6:0] OP_SW  = 7'b010_0011;
  localparam logic [6:0] OP_R   = 7'b011_0011;
  localparam logic [6:0] OP_BEQ = 7'b110_0011;
  localparam logic [6:0] OP_JAL = 7'b110_1111;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: one synchronous write port for program
// load and one asynchronous read port for fetch. Contents survive reset.
module instr_mem #(
  parameter int IMEM_WORDS = 64
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(IMEM_WORDS)-1:0] waddr,
  input  logic [31:0]                   wdata,
  input  logic [$clog2(IMEM_WORDS)-1:0] raddr,
  output logic [31:0]                   rdata
);

  logic [31:0] mem_q [IMEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // A write to the word being read shows up only after the edge.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch fault
// detection and the RUN/HALT state machine around the instruction memory.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | fetching; PC advances by 4 or to the branch/jump target
//   HALT  | fault seen; PC frozen, NOP presented, left only by reset
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          branch,
  input  logic                          zero,
  input  logic                          jump,
  input  logic [31:0]                   immExt,
  input  logic                          imemWe,
  input  logic [$clog2(IMEM_WORDS)-1:0] imemWaddr,
  input  logic [31:0]                   imemWdata,
  output logic [31:0]                   pc,
  output logic [31:0]                   pcPlus4,
  output logic [31:0]                   instr,
  output logic [6:0]                    opcode,
  output logic                          instrValid,
  output logic                          halted,
  output logic [1:0]                    faultCode
);

  localparam int          AW    = $clog2(IMEM_WORDS);
  localparam logic [29:0] DEPTH = 30'(IMEM_WORDS);

  fetch_state_e state_q, state_d;
  fault_e       fault_q, fault_d;
  logic [31:0]  pc_q, pc_d;

  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic        pc_src;
  logic        in_range;
  logic [31:0] mem_rdata;

  instr_mem #(
    .IMEM_WORDS(IMEM_WORDS)
  ) u_instr_mem (
    .clk  (clk),
    .we   (imemWe),
    .waddr(imemWaddr),
    .wdata(imemWdata),
    .raddr(pc_q[2 +: AW]),
    .rdata(mem_rdata)
  );

  assign pc_plus4  = pc_q + 32'd4;
  assign pc_target = pc_q + immExt;
  assign pc_src    = (branch & zero) | jump;
  assign in_range  = pc_q[31:2] < DEPTH;

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      RUN: begin
        if (!stall) begin
          // Range fault outranks a misaligned target in the same cycle.
          if (!in_range) begin
            fault_d = FAULT_RANGE;
            state_d = HALT;
          end else if (pc_src && is_misaligned(pc_target)) begin
            fault_d = FAULT_MISALIGN;
            state_d = HALT;
          end else begin
            pc_d = pc_src ? pc_target : pc_plus4;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      fault_q <= FAULT_NONE;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4;
  assign instr      = (state_q == RUN && in_range) ? mem_rdata : NOP_INSTR;
  assign opcode     = instr[6:0];
  assign instrValid = !reset && state_q == RUN && in_range;
  assign halted     = state_q == HALT;
  assign faultCode  = fault_q;

endmodule
